// File: rtl/board_sweep_arbiter.sv
// Round-robin arbiter for two board-sweep requesters. The granted requester
// gets a row-major walk over every cell of a dim x dim board, presented on a
// valid/ready stream, followed by a one-cycle done pulse. Dropping the request
// mid-walk aborts the sweep without a done pulse.
module board_sweep_arbiter #(
    parameter int NREQ  = 2,
    parameter int DIM_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [DIM_W-1:0] dimension_size,
    input  logic             cell_ready,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             cell_valid,
    output logic [DIM_W-1:0] cell_x,
    output logic [DIM_W-1:0] cell_y,
    output logic             cell_last,
    output logic [NREQ-1:0]  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]  r_done, w_done_nxt;
    logic             r_last_gnt, w_last_gnt_nxt;
    logic [DIM_W-1:0] r_dim, w_dim_nxt;
    logic [DIM_W-1:0] r_x, w_x_nxt;
    logic [DIM_W-1:0] r_y, w_y_nxt;
    logic             r_valid, w_valid_nxt;

    logic             w_win;
    logic [NREQ-1:0]  w_win_oh;
    logic             w_req_held;
    logic [DIM_W-1:0] w_dim_m1;
    logic             w_x_end;
    logic             w_y_end;

    // Arbitration and sweep-position decode shared by the next-state logic
    always_comb begin
        // On a tie the requester not granted last wins; otherwise the sole requester wins.
        w_win      = (req == 2'b11) ? ~r_last_gnt : req[1];
        w_win_oh   = NREQ'(1) << w_win;
        w_req_held = |(req & r_gnt);
        w_dim_m1   = r_dim - 1'b1;
        w_x_end    = (r_x == w_dim_m1);
        w_y_end    = (r_y == w_dim_m1);
    end

    // Next-state and next-output computation for the grant/sweep FSM
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path infers a latch.
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_done_nxt     = '0;
        w_last_gnt_nxt = r_last_gnt;
        w_dim_nxt      = r_dim;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_valid_nxt    = r_valid;

        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_gnt_nxt      = w_win_oh;
                    w_last_gnt_nxt = w_win;
                    w_dim_nxt      = dimension_size;
                    w_x_nxt        = '0;
                    w_y_nxt        = '0;
                    if (dimension_size == '0) begin
                        // Empty board: skip straight to completion.
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = w_win_oh;
                    end else begin
                        w_state_nxt = S_SWEEP;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (!w_req_held) begin
                    // Abort takes priority over a coincident transfer.
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (r_valid && cell_ready) begin
                    if (!w_x_end) begin
                        w_x_nxt = r_x + 1'b1;
                    end else if (!w_y_end) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                        w_done_nxt  = r_gnt;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_last_gnt <= 1'b1;
            r_dim      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_dim      <= w_dim_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign busy       = |r_gnt;
    assign done       = r_done;
    assign cell_valid = r_valid;
    assign cell_x     = r_x;
    assign cell_y     = r_y;
    assign cell_last  = r_valid && w_x_end && w_y_end;

endmodule

// File: tb/tb_board_sweep_arbiter.sv
// Self-checking bench for board_sweep_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cell-index reference model.
module tb_board_sweep_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [4:0] dimension_size;
    logic       cell_ready;
    logic [1:0] gnt;
    logic       busy;
    logic       cell_valid;
    logic [4:0] cell_x;
    logic [4:0] cell_y;
    logic       cell_last;
    logic [1:0] done;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: which requester owns the board, the board size and
    // the linear index of the cell on offer (row-major), plus a done flag.
    int m_owner;
    int m_last_owner;
    int m_dim;
    int m_k;
    bit m_valid;
    bit m_done;

    int obs_xfers;
    int obs_last;
    int obs_valid;

    board_sweep_arbiter #(.NREQ(2), .DIM_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .dimension_size (dimension_size),
        .cell_ready     (cell_ready),
        .gnt            (gnt),
        .busy           (busy),
        .cell_valid     (cell_valid),
        .cell_x         (cell_x),
        .cell_y         (cell_y),
        .cell_last      (cell_last),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner      = -1;
        m_last_owner = 1;
        m_dim        = 0;
        m_k          = 0;
        m_valid      = 1'b0;
        m_done       = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int w;
        if (m_done) begin
            m_done  = 1'b0;
            m_owner = -1;
            m_valid = 1'b0;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) w = 1 - m_last_owner;
                else              w = req[0] ? 0 : 1;
                m_owner      = w;
                m_last_owner = w;
                m_dim        = int'(dimension_size);
                m_k          = 0;
                m_valid      = (m_dim != 0);
                m_done       = (m_dim == 0);
            end
        end else begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_valid = 1'b0;
            end else if (cell_ready) begin
                if (m_k == m_dim * m_dim - 1) begin
                    m_valid = 1'b0;
                    m_done  = 1'b1;
                end else begin
                    m_k++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [1:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
        check("gnt", gnt, e_gnt);
        check("busy", busy, e_gnt != 2'b00);
        check("done", done, m_done ? e_gnt : 2'b00);
        check("cell_valid", cell_valid, m_valid);
        check("cell_last", cell_last, m_valid && (m_k == m_dim * m_dim - 1));
        if (m_valid) begin
            check("cell_x", cell_x, m_k % m_dim);
            check("cell_y", cell_y, m_k / m_dim);
        end
    endtask

    // One clock: tally what the DUT is offering, take the edge, then compare.
    task automatic step();
        if (cell_valid) obs_valid++;
        if (cell_valid && cell_ready) obs_xfers++;
        if (cell_last && cell_ready) obs_last++;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_obs();
        obs_xfers = 0;
        obs_last  = 0;
        obs_valid = 0;
    endtask

    // Run until the model reports done, then drop all requests.
    // mode 0: ready held high; mode 1: ready follows 1,0,0,1 repeating.
    task automatic run_until_done(input int budget, input int mode);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mode == 1) cell_ready = (i % 4 == 0) || (i % 4 == 3);
            else           cell_ready = 1'b1;
            step();
            if (m_done) begin
                seen = 1'b1;
                req  = 2'b00;
                break;
            end
        end
        check("done_within_budget", seen, 1'b1);
        step();
    endtask

    initial begin
        rst            = 1'b0;
        req            = 2'b00;
        dimension_size = '0;
        cell_ready     = 1'b0;
        model_reset();
        clear_obs();
        #12;
        compare_all();
        check("reset_x", cell_x, 0);
        check("reset_y", cell_y, 0);
        rst = 1'b1;
        step();

        // Single sweep of a 3x3 board.
        clear_obs();
        req = 2'b01; dimension_size = 5'd3;
        run_until_done(20, 0);
        check("single_cells", obs_xfers, 9);
        check("single_last", obs_last, 1);
        check("single_idle_gnt", gnt, 2'b00);

        // Backpressure on a 2x2 board.
        clear_obs();
        req = 2'b01; dimension_size = 5'd2;
        run_until_done(30, 1);
        check("bp_cells", obs_xfers, 4);
        check("bp_last", obs_last, 1);

        // Round robin with both requesting, 1x1 board.
        req = 2'b11; dimension_size = 5'd1; cell_ready = 1'b1;
        repeat (9) step();
        req = 2'b00;
        step(); step();

        // Empty board for requester 1.
        clear_obs();
        req = 2'b10; dimension_size = 5'd0;
        run_until_done(5, 0);
        check("empty_valid_cycles", obs_valid, 0);

        // Abort after 5 transfers on a 4x4 board, then restart.
        req = 2'b01; dimension_size = 5'd4; cell_ready = 1'b1;
        step();
        for (int i = 0; i < 10 && m_k < 5; i++) step();
        check("abort_pos", m_k, 5);
        req = 2'b00;
        step();
        check("abort_gnt", gnt, 2'b00);
        check("abort_valid", cell_valid, 1'b0);
        req = 2'b01;
        step();
        check("restart_x", cell_x, 0);
        check("restart_y", cell_y, 0);
        req = 2'b00;
        step(); step();

        // Asynchronous reset in the middle of a sweep at cell (2,1).
        req = 2'b01; dimension_size = 5'd3; cell_ready = 1'b1;
        step();
        for (int i = 0; i < 10 && m_k < 5; i++) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_x", cell_x, 0);
        check("arst_y", cell_y, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 2'b11; dimension_size = 5'd1;
        step();
        check("arst_first_tie", gnt, 2'b01);
        req = 2'b00;
        step(); step(); step();

        // Randomized traffic with occasional request drops and stalls.
        req = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 11) == 0) req[1] = ~req[1];
            dimension_size = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) dimension_size = 5'd31;
            cell_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/board_sweep_arbiter.md
# board_sweep_arbiter

Shares the board-cell sweep between two requesters, for example board clear and neighbour-count pass. It sits between those requesters and the board memory port. It grants one requester at a time using round-robin, then walks every cell of the dimension_size × dimension_size board in row-major order with a valid/ready handshake. When the walk finishes it pulses done to the granted requester.

## Interface
Parameters:
- NREQ, 2, number of requesters (fixed at 2 for this revision).
- DIM_W, 5, width of dimension and coordinate signals.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester sweep request, level; held until done or abort.
- dimension_size  in  DIM_W  board side length; sampled only at grant.
- cell_ready  in  1  consumer accepts current cell.
- gnt  out  NREQ  one-hot grant, high from grant through the done cycle.
- busy  out  1  high whenever gnt is non-zero.
- cell_valid  out  1  cell_x/cell_y are valid.
- cell_x, cell_y  out  DIM_W each  current cell column and row, range 0..dim-1.
- cell_last  out  1  high with cell_valid on cell (dim-1, dim-1).
- done  out  NREQ  one-cycle pulse to the granted requester on sweep completion.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE:
  - If any req bit is set at a clock edge, select a winner and load gnt, latch dimension_size into dim_q, and set x=y=0.
  - If dim_q == 0, go to DONE with cell_valid=0 (empty sweep).
  - Otherwise go to SWEEP with cell_valid=1.
- Arbitration is round-robin and uses a last_gnt pointer.
  - With a single request, that requester wins.
  - With both requesting, the one not granted last wins.
  - Reset value of last_gnt = 1, so req[0] wins the first tie.
  - last_gnt updates at every grant, including grants that later abort.
- SWEEP:
  - A transfer occurs when cell_valid && cell_ready.
  - On a transfer with x < dim_q-1: x increments.
  - On a transfer with x == dim_q-1 and y < dim_q-1: x goes to 0 and y increments.
  - On a transfer of the last cell: cell_valid drops and the state goes to DONE.
  - With no transfer, x, y and cell_valid hold (stable under backpressure).
- DONE:
  - done[granted] = 1 for exactly one cycle; gnt is still high.
  - Next state is IDLE with gnt=0.
- Abort: if req[granted] deasserts during SWEEP, the next state is IDLE.
  - gnt, cell_valid and cell_last drop the following cycle.
  - No done pulse is issued.
  - This is the only case in which cell_valid falls without a transfer.
- Changes to dimension_size after grant are ignored until the next grant.
- The non-granted requester's req is ignored until IDLE.
- Coordinate arithmetic is DIM_W wide; because dim_q ≤ 31, x and y never wrap.

## Timing
- Reset values: gnt=0, busy=0, cell_valid=0, cell_x=0, cell_y=0, cell_last=0, done=0, state IDLE, last_gnt=1.
- Reset asserted mid-sweep returns everything to these values immediately; no done pulse is issued.
- All outputs are registered, except cell_last and busy, which are decoded from registers.
- Grant latency: req high at edge N, so gnt and cell_valid (cell 0,0) are high after edge N.
- With cell_ready held high, a sweep of dim≥1 presents dim² cells on dim² consecutive cycles, followed by 1 DONE cycle.
  - That gives dim²+1 cycles of gnt in total.
- Empty sweep (dim=0): 1 DONE cycle of gnt.
- At least one IDLE cycle (gnt=0) separates consecutive grants.

## Test plan
- Single sweep: req=01, dim=3, cell_ready=1 → 9 cells (0,0),(1,0),(2,0),(0,1)…(2,2) on consecutive cycles; cell_last only on (2,2); done=01 one cycle later; gnt low after.
- Backpressure: dim=2, cell_ready toggled 1,0,0,1,… → coordinates hold during ready=0; exactly 4 transfers; done after the 4th.
- Round-robin: req=11 held, dim=1 → grants alternate 01, 10, 01, each with 1 cell, one done, and one IDLE gap between grants.
- Empty board: req=10, dim=0 → gnt=10 for one cycle with done=10; cell_valid never high.
- Abort: req=01, dim=4, drop req[0] after 5 transfers → next cycle gnt=0, cell_valid=0, no done; a subsequent req=01 restarts at (0,0).
- Async reset mid-sweep: assert rst low between edges at cell (2,1) → all outputs zero immediately; after release, req=11 grants req[0] first.
